// File: rtl/i2s_pkg.sv
// Shared I2S definitions: word/frame geometry and the sample-pair payload.
package i2s_pkg;

  localparam int unsigned I2S_WORD_BITS   = 16;
  localparam int unsigned I2S_FRAME_SLOTS = 32;
  localparam int unsigned I2S_SLOT_W      = $clog2(I2S_FRAME_SLOTS);

  typedef struct packed {
    logic signed [I2S_WORD_BITS-1:0] l;
    logic signed [I2S_WORD_BITS-1:0] r;
  } i2s_pair_t;

  // Word select for a slot: left half of the frame is 0, right half is 1.
  function automatic logic i2s_ws_of(input logic [I2S_SLOT_W-1:0] slot);
    return slot >= I2S_SLOT_W'(I2S_FRAME_SLOTS / 2);
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides CLK_AUDIO by 2*CLK_DIV and strobes the cycle BCLK falls.
module i2s_bclk_gen #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic CLK_AUDIO,
  input  logic RESET,
  output logic bclk,
  output logic fall_c
);

  localparam int unsigned   DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tc_c;

  assign tc_c   = (div_cnt == DIV_LAST);
  assign fall_c = tc_c & bclk;

  always_ff @(posedge CLK_AUDIO) begin
    if (RESET) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (tc_c) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S bus-master transmitter: one-deep sample buffer, 32-slot frame, MSB-first shifter.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic                            CLK_AUDIO,
  input  logic                            RESET,
  input  logic signed [I2S_WORD_BITS-1:0] sample_l,
  input  logic signed [I2S_WORD_BITS-1:0] sample_r,
  input  logic                            sample_valid,
  output logic                            sample_ready,
  output logic                            i2s_bclk,
  output logic                            i2s_ws,
  output logic                            i2s_data,
  output logic                            frame_load,
  output logic                            underrun
);

  localparam int unsigned             SHIFT_W   = 2 * I2S_WORD_BITS;
  localparam logic [I2S_SLOT_W-1:0]   SLOT_LOAD = I2S_SLOT_W'(1);

  logic                  fall_c;
  logic [I2S_SLOT_W-1:0] slot;
  logic [I2S_SLOT_W-1:0] slot_nxt_c;
  logic [SHIFT_W-1:0]    shifter;
  i2s_pair_t             hold;
  i2s_pair_t             prev_pair;
  i2s_pair_t             load_pair_c;
  logic                  hold_valid;
  logic                  hold_valid_nxt_c;
  logic                  take_c;
  logic                  load_c;

  i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk_gen (
    .CLK_AUDIO (CLK_AUDIO),
    .RESET     (RESET),
    .bclk      (i2s_bclk),
    .fall_c    (fall_c)
  );

  assign take_c      = sample_valid & sample_ready;
  assign slot_nxt_c  = slot + I2S_SLOT_W'(1);
  assign load_c      = fall_c & (slot_nxt_c == SLOT_LOAD);
  assign load_pair_c = hold_valid ? hold : prev_pair;
  assign i2s_data    = shifter[SHIFT_W-1];

  // A load empties the buffer; a transfer on the same edge refills it.
  always_comb begin
    hold_valid_nxt_c = hold_valid;
    if (load_c) hold_valid_nxt_c = 1'b0;
    if (take_c) hold_valid_nxt_c = 1'b1;
  end

  always_ff @(posedge CLK_AUDIO) begin
    if (RESET) begin
      slot         <= '0;
      shifter      <= '0;
      hold         <= '0;
      prev_pair    <= '0;
      hold_valid   <= 1'b0;
      sample_ready <= 1'b1;
      frame_load   <= 1'b0;
      underrun     <= 1'b0;
      i2s_ws       <= 1'b0;
    end else begin
      frame_load   <= load_c;
      hold_valid   <= hold_valid_nxt_c;
      sample_ready <= ~hold_valid_nxt_c | load_c;
      if (take_c) begin
        hold <= {sample_l, sample_r};
      end
      if (fall_c) begin
        slot   <= slot_nxt_c;
        i2s_ws <= i2s_ws_of(slot_nxt_c);
        if (load_c) begin
          shifter   <= load_pair_c;
          prev_pair <= load_pair_c;
          if (!hold_valid) underrun <= 1'b1;
        end else begin
          shifter <= {shifter[SHIFT_W-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx at CLK_DIV=8 and CLK_DIV=2: frame-level model plus bit-level I2S receiver.
`timescale 1ns/1ps
module tb_i2s_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned D     = (g == 0) ? 8 : 2;
    localparam int unsigned FRAME = 64 * D;
    localparam logic [15:0] L1    = (g == 0) ? 16'hA5C3 : 16'h0001;
    localparam logic [15:0] R1    = (g == 0) ? 16'h1234 : 16'hFFFE;

    logic        rst, valid, ready, bclk, ws, data, fload, und;
    logic [15:0] sl, sr_in;
    bit          fin = 1'b0;

    i2s_tx #(.CLK_DIV(D)) dut (
      .CLK_AUDIO    (clk),
      .RESET        (rst),
      .sample_l     (sl),
      .sample_r     (sr_in),
      .sample_valid (valid),
      .sample_ready (ready),
      .i2s_bclk     (bclk),
      .i2s_ws       (ws),
      .i2s_data     (data),
      .frame_load   (fload),
      .underrun     (und)
    );

    // Frame-level reference: cycle count since reset, a one-pair buffer and the last sent pair.
    int unsigned cyc = 0;
    bit          started = 1'b0;
    bit          m_ready, m_fload, m_und, m_acc, buf_v;
    logic [31:0] buf_p, last_p;
    logic [31:0] exp_q[$];

    always @(posedge clk) begin
      started = 1'b1;
      m_acc   = 1'b0;
      if (rst) begin
        cyc = 0; m_ready = 1'b1; m_fload = 1'b0; m_und = 1'b0;
        buf_v = 1'b0; buf_p = '0; last_p = '0;
        exp_q.delete();
      end else begin
        cyc++;
        m_acc   = valid && m_ready;
        m_fload = (cyc >= 2 * D) && (((cyc - 2 * D) % FRAME) == 0);
        if (m_fload) begin
          if (buf_v) begin
            last_p = buf_p;
            buf_v  = 1'b0;
          end else begin
            m_und = 1'b1;
          end
          exp_q.push_back(last_p);
        end
        if (m_acc) begin
          buf_p = {sl, sr_in};
          buf_v = 1'b1;
        end
        m_ready = !buf_v || m_fload;
      end
    end

    // Bus monitor and I2S receiver sampling DATA/WS on each BCLK rise.
    logic [15:0] rx_sr, rx_l;
    logic [31:0] got_p;
    bit          rx_have_l, last_ws, prev_bclk, seen_rise, have_fl;
    int unsigned rx_frames = 0;
    int unsigned last_fl;

    always @(negedge clk) begin
      if (started) begin
        check_eq($sformatf("d%0d_bclk", D), 32'(bclk), 32'((cyc / D) % 2));
        check_eq($sformatf("d%0d_ws", D), 32'(ws), 32'(((cyc / (2 * D)) % 32) >= 16));
        check_eq($sformatf("d%0d_ready", D), 32'(ready), 32'(m_ready));
        check_eq($sformatf("d%0d_frame_load", D), 32'(fload), 32'(m_fload));
        check_eq($sformatf("d%0d_underrun", D), 32'(und), 32'(m_und));
        if (rst) begin
          rx_sr = '0; rx_have_l = 1'b0; last_ws = 1'b0;
          prev_bclk = 1'b0; seen_rise = 1'b0; have_fl = 1'b0;
        end else begin
          if (fload) begin
            if (have_fl) check_eq($sformatf("d%0d_load_interval", D), cyc - last_fl, FRAME);
            have_fl = 1'b1;
            last_fl = cyc;
          end
          if (bclk && !prev_bclk) begin
            if (!seen_rise) begin
              check_eq($sformatf("d%0d_first_rise", D), cyc, D);
              seen_rise = 1'b1;
            end
            rx_sr = {rx_sr[14:0], data};
            if (ws != last_ws) begin
              if (!last_ws) begin
                rx_l      = rx_sr;
                rx_have_l = 1'b1;
              end else if (rx_have_l) begin
                check_eq($sformatf("d%0d_rx_pending", D), 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                  got_p = {rx_l, rx_sr};
                  check_eq($sformatf("d%0d_rx_pair", D), got_p, exp_q.pop_front());
                end
                rx_have_l = 1'b0;
                rx_frames++;
              end
              last_ws = ws;
            end
          end
          prev_bclk = bclk;
        end
      end
    end

    // Stimulus phases: back-pressure, single pairs with underrun, random, mid-frame reset.
    initial begin : drive
      logic [15:0] cnt;
      bit          got;
      rst = 1'b1; valid = 1'b0; sl = '0; sr_in = '0;
      repeat (5) @(negedge clk);
      check_eq($sformatf("d%0d_rst_bclk", D), 32'(bclk), 32'd0);
      check_eq($sformatf("d%0d_rst_ws", D), 32'(ws), 32'd0);
      check_eq($sformatf("d%0d_rst_data", D), 32'(data), 32'd0);
      check_eq($sformatf("d%0d_rst_ready", D), 32'(ready), 32'd1);
      check_eq($sformatf("d%0d_rst_fload", D), 32'(fload), 32'd0);
      check_eq($sformatf("d%0d_rst_underrun", D), 32'(und), 32'd0);
      rst = 1'b0;

      for (int ph = 0; ph < 5; ph++) begin
        case (ph)
          0: begin
            cnt = 16'd1; valid = 1'b1; sl = cnt; sr_in = ~cnt;
            for (int k = 0; k < 6 * FRAME; k++) begin
              @(negedge clk);
              if (m_acc) begin cnt = cnt + 16'd1; sl = cnt; sr_in = ~cnt; end
            end
            valid = 1'b0;
            check_eq($sformatf("d%0d_bp_underrun", D), 32'(und), 32'd0);
          end
          1, 2: begin
            sl = (ph == 1) ? L1 : 16'h7FFF;
            sr_in = (ph == 1) ? R1 : 16'h8000;
            valid = 1'b1; got = 1'b0;
            for (int k = 0; k < 4 * FRAME && !got; k++) begin
              @(negedge clk);
              got = m_acc;
            end
            valid = 1'b0;
            check_eq($sformatf("d%0d_push_accepted", D), 32'(got), 32'd1);
            repeat (3 * FRAME) @(negedge clk);
            check_eq($sformatf("d%0d_underrun_sticky", D), 32'(und), 32'd1);
          end
          3: begin
            for (int k = 0; k < 8 * FRAME; k++) begin
              valid = ($urandom_range(0, 2) == 0);
              sl    = 16'($urandom);
              sr_in = 16'($urandom);
              @(negedge clk);
            end
            valid = 1'b0;
          end
          default: begin
            got = 1'b0;
            for (int k = 0; k < 2 * FRAME && !got; k++) begin
              @(negedge clk);
              got = (((cyc / (2 * D)) % 32) == 20);
            end
            check_eq($sformatf("d%0d_reached_slot20", D), 32'(got), 32'd1);
            rst = 1'b1;
            @(negedge clk);
            check_eq($sformatf("d%0d_mid_rst_bclk", D), 32'(bclk), 32'd0);
            check_eq($sformatf("d%0d_mid_rst_ws", D), 32'(ws), 32'd0);
            check_eq($sformatf("d%0d_mid_rst_data", D), 32'(data), 32'd0);
            check_eq($sformatf("d%0d_mid_rst_underrun", D), 32'(und), 32'd0);
            check_eq($sformatf("d%0d_mid_rst_ready", D), 32'(ready), 32'd1);
            rst = 1'b0;
            sl = 16'hBEEF; sr_in = 16'h0F0F; valid = 1'b1;
            @(negedge clk);
            valid = 1'b0;
            repeat (3 * FRAME) @(negedge clk);
            check_eq($sformatf("d%0d_after_rst_underrun", D), 32'(und), 32'd1);
          end
        endcase
      end
      check_eq($sformatf("d%0d_rx_frame_count", D), 32'(rx_frames >= 20), 32'd1);
      fin = 1'b1;
    end
  end

  initial begin : top_ctl
    bit all_done;
    all_done = 1'b0;
    for (int k = 0; k < 60000 && !all_done; k++) begin
      @(negedge clk);
      all_done = g_inst[0].fin && g_inst[1].fin;
    end
    check_eq("completion", 32'(all_done), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
